tl_ram_arbiter: RTL and testbench

//  Shares one TileLink-UL RAM slave between two masters: m0 = ifetch, m1 = LSU.

---
 rtl/tl_arb_pkg.sv | 36 +++
 rtl/tilelink.sv | 34 +++
 rtl/rr_arb2.sv | 16 +
 rtl/tl_ram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_tl_ram_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_arb_pkg.sv
// Shared TileLink-UL types, opcodes and FSM encoding for the two-master RAM arbiter.
package tl_arb_pkg;

  localparam int unsigned TL_AW   = 32;
  localparam int unsigned TL_DW   = 32;
  localparam int unsigned TL_MW   = TL_DW / 8;
  localparam int unsigned TL_SZW  = 3;
  localparam int unsigned TL_SRCW = 4;

  localparam logic [2:0] TL_PUT_F           = 3'd0;
  localparam logic [2:0] TL_PUT_P           = 3'd1;
  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {IDLE, REQ_A, WAIT_D} arb_state_t;

  typedef struct packed {
    logic [2:0]         opcode;
    logic [TL_SZW-1:0]  size;
    logic [TL_SRCW-1:0] source;
    logic [TL_AW-1:0]   address;
    logic [TL_DW-1:0]   data;
    logic [TL_MW-1:0]   mask;
  } a_beat_t;

  // D opcode the arbiter fabricates when the slave never answers.
  function automatic logic [2:0] tl_ack_for(input logic [2:0] op);
    case (op)
      TL_PUT_F, TL_PUT_P: return TL_ACCESS_ACK;
      TL_GET:             return TL_ACCESS_ACK_DATA;
      default:            return TL_ACCESS_ACK_DATA;
    endcase
  endfunction

endpackage

// File: rtl/tilelink.sv
// TileLink-UL A/D channel bundle; master drives A and d_ready, slave drives D and a_ready.
interface tilelink;
  import tl_arb_pkg::*;

  logic                a_valid;
  logic                a_ready;
  logic [2:0]          a_opcode;
  logic [TL_SZW-1:0]   a_size;
  logic [TL_SRCW-1:0]  a_source;
  logic [TL_AW-1:0]    a_address;
  logic [TL_MW-1:0]    a_mask;
  logic [TL_DW-1:0]    a_data;

  logic                d_valid;
  logic                d_ready;
  logic [2:0]          d_opcode;
  logic [TL_SZW-1:0]   d_size;
  logic [TL_SRCW-1:0]  d_source;
  logic [TL_DW-1:0]    d_data;

  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_size, d_source, d_data,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_size, d_source, d_data,
    input  d_ready
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to ptr.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  always_comb begin
    gnt_idx = 1'b0;
    if (req == 2'b11) gnt_idx = ptr;
    else if (req[1])  gnt_idx = 1'b1;
    gnt = (|req) ? (2'b01 << gnt_idx) : 2'b00;
  end

endmodule

// File: rtl/tl_ram_arbiter.sv
// Shares one TileLink-UL RAM slave between ifetch (m0) and LSU (m1), one transaction
// in flight, with a response watchdog that answers on behalf of a hung slave.
module tl_ram_arbiter
  import tl_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  tilelink.slave           m0,
  tilelink.slave           m1,
  tilelink.master          ram,
  output logic             busy,
  output logic             grant,
  output logic             timeout,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned       WDOG_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic              WDOG_EN   = 1'(TIMEOUT_CYCLES != 0);

  arb_state_t        state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              grant_q, grant_d;
  a_beat_t           beat_q, beat_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timed_out_q, timed_out_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic [1:0]         win_gnt;
  logic               win_idx;
  a_beat_t            m0_beat, m1_beat;
  logic               sel_d_ready, sel_d_valid, done, expire, a_take;
  logic [2:0]         d_opcode;
  logic [TL_SZW-1:0]  d_size;
  logic [TL_SRCW-1:0] d_source;
  logic [TL_DW-1:0]   d_data;

  rr_arb2 u_rr (
    .req     ({m1.a_valid, m0.a_valid}),
    .ptr     (rr_ptr_q),
    .gnt     (win_gnt),
    .gnt_idx (win_idx)
  );

  assign m0_beat = '{opcode: m0.a_opcode, size: m0.a_size, source: m0.a_source,
                     address: m0.a_address, data: m0.a_data, mask: m0.a_mask};
  assign m1_beat = '{opcode: m1.a_opcode, size: m1.a_size, source: m1.a_source,
                     address: m1.a_address, data: m1.a_data, mask: m1.a_mask};

  always_comb begin
    sel_d_ready = grant_q ? m1.d_ready : m0.d_ready;
    sel_d_valid = (state_q == WAIT_D) & (timed_out_q | ram.d_valid);
    done        = sel_d_valid & sel_d_ready;
    // Once the synthesized response is pending the watchdog is parked, so it fires once.
    expire      = WDOG_EN & (state_q != IDLE) & ~timed_out_q & ~done & (wdog_q == WDOG_LAST);
    a_take      = (state_q == REQ_A) & (ram.a_ready | expire);
    if (timed_out_q) begin
      d_opcode = tl_ack_for(beat_q.opcode);
      d_size   = beat_q.size;
      d_source = beat_q.source;
      d_data   = '0;
    end else begin
      d_opcode = ram.d_opcode;
      d_size   = ram.d_size;
      d_source = ram.d_source;
      d_data   = ram.d_data;
    end
  end

  // NOTE: every always_comb target gets its default before the case so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    beat_d      = beat_q;
    wdog_d      = wdog_q;
    timed_out_d = timed_out_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (|win_gnt) begin
          state_d     = REQ_A;
          grant_d     = win_idx;
          beat_d      = win_gnt[1] ? m1_beat : m0_beat;
          wdog_d      = '0;
          timed_out_d = 1'b0;
        end
      end
      REQ_A: begin
        wdog_d = wdog_q + WDOG_W'(1);
        if (expire) begin
          state_d     = WAIT_D;
          timed_out_d = 1'b1;
        end else if (ram.a_ready) begin
          state_d = WAIT_D;
        end
      end
      WAIT_D: begin
        if (done) begin
          state_d     = IDLE;
          rr_ptr_d    = ~grant_q;
          wdog_d      = '0;
          timed_out_d = 1'b0;
        end else if (expire) begin
          timed_out_d = 1'b1;
        end else if (!timed_out_q) begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (expire && !(&err_cnt_q)) err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours; the latched A beat is reset too so ram.a_* is
  // never X when the RAM monitor looks at it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      grant_q     <= 1'b0;
      beat_q      <= '0;
      wdog_q      <= '0;
      timed_out_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      beat_q      <= beat_d;
      wdog_q      <= wdog_d;
      timed_out_q <= timed_out_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign m0.a_ready  = a_take & ~grant_q;
  assign m1.a_ready  = a_take & grant_q;
  assign m0.d_valid  = sel_d_valid & ~grant_q;
  assign m1.d_valid  = sel_d_valid & grant_q;
  assign m0.d_opcode = d_opcode;
  assign m0.d_size   = d_size;
  assign m0.d_source = d_source;
  assign m0.d_data   = d_data;
  assign m1.d_opcode = d_opcode;
  assign m1.d_size   = d_size;
  assign m1.d_source = d_source;
  assign m1.d_data   = d_data;

  assign ram.a_valid   = (state_q == REQ_A);
  assign ram.a_opcode  = beat_q.opcode;
  assign ram.a_size    = beat_q.size;
  assign ram.a_source  = beat_q.source;
  assign ram.a_address = beat_q.address;
  assign ram.a_data    = beat_q.data;
  assign ram.a_mask    = beat_q.mask;
  // Idle sinks late beats from a slave we already gave up on.
  assign ram.d_ready   = ((state_q == IDLE) & ~rst) |
                         ((state_q == WAIT_D) & ~timed_out_q & sel_d_ready);

  assign busy      = (state_q != IDLE);
  assign grant     = grant_q;
  assign timeout   = expire;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_tl_ram_arbiter.sv
// Scenario bench for tl_ram_arbiter: per-feature tasks plus an A/D scoreboard monitor.
module tb_tl_ram_arbiter;
  import tl_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy, grant, timeout;
  logic [15:0] err_count;

  tilelink m0_if ();
  tilelink m1_if ();
  tilelink ram_if ();

  tl_ram_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .ram       (ram_if),
    .busy      (busy),
    .grant     (grant),
    .timeout   (timeout),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_a_t;

  typedef struct {
    int          m;
    logic [2:0]  op;
    logic [31:0] data;
    logic [3:0]  src;
  } exp_d_t;

  exp_a_t exp_a_q[$];
  exp_d_t exp_d_q[$];
  int     tests = 0;
  int     fails = 0;
  int     m_acc[2] = '{0, 0};

  // Scoreboard: every RAM A handshake and every master D handshake pops an expectation.
  always @(negedge clk) begin
    exp_a_t ea;
    exp_d_t ed;
    if (!rst) begin
      if (m0_if.a_valid && m0_if.a_ready) m_acc[0]++;
      if (m1_if.a_valid && m1_if.a_ready) m_acc[1]++;
      if (ram_if.a_valid && ram_if.a_ready) begin
        tests++;
        if (exp_a_q.size() == 0) begin
          fails++;
          $display("FAIL ram_a_beat: got op=%0d addr=%h with nothing expected", ram_if.a_opcode, ram_if.a_address);
        end else begin
          ea = exp_a_q.pop_front();
          if (ram_if.a_opcode !== ea.op || ram_if.a_address !== ea.addr || ram_if.a_data !== ea.data) begin
            fails++;
            $display("FAIL ram_a_beat: got op=%0d addr=%h data=%h expected op=%0d addr=%h data=%h",
                     ram_if.a_opcode, ram_if.a_address, ram_if.a_data, ea.op, ea.addr, ea.data);
          end
        end
      end
      for (int k = 0; k < 2; k++) begin
        logic       dv, dr;
        logic [2:0] dop;
        logic [31:0] dd;
        logic [3:0] ds;
        dv  = k ? m1_if.d_valid  : m0_if.d_valid;
        dr  = k ? m1_if.d_ready  : m0_if.d_ready;
        dop = k ? m1_if.d_opcode : m0_if.d_opcode;
        dd  = k ? m1_if.d_data   : m0_if.d_data;
        ds  = k ? m1_if.d_source : m0_if.d_source;
        if (dv && dr) begin
          tests++;
          if (exp_d_q.size() == 0) begin
            fails++;
            $display("FAIL m_d_beat: m%0d got data=%h with nothing expected", k, dd);
          end else begin
            ed = exp_d_q.pop_front();
            if (ed.m != k || dop !== ed.op || dd !== ed.data || ds !== ed.src) begin
              fails++;
              $display("FAIL m_d_beat: got m%0d op=%0d data=%h src=%0d expected m%0d op=%0d data=%h src=%0d",
                       k, dop, dd, ds, ed.m, ed.op, ed.data, ed.src);
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_if.a_valid = 1'b0; m0_if.a_opcode = '0; m0_if.a_size = '0; m0_if.a_source = '0;
    m0_if.a_address = '0; m0_if.a_mask = '0; m0_if.a_data = '0; m0_if.d_ready = 1'b1;
    m1_if.a_valid = 1'b0; m1_if.a_opcode = '0; m1_if.a_size = '0; m1_if.a_source = '0;
    m1_if.a_address = '0; m1_if.a_mask = '0; m1_if.a_data = '0; m1_if.d_ready = 1'b1;
    ram_if.a_ready = 1'b0; ram_if.d_valid = 1'b0; ram_if.d_opcode = '0;
    ram_if.d_size = '0; ram_if.d_source = '0; ram_if.d_data = '0;
  endtask

  task automatic drive_req(input int m, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] src);
    if (m == 0) begin
      m0_if.a_valid = 1'b1; m0_if.a_opcode = op; m0_if.a_size = 3'd2; m0_if.a_source = src;
      m0_if.a_address = addr; m0_if.a_mask = 4'hF; m0_if.a_data = data;
    end else begin
      m1_if.a_valid = 1'b1; m1_if.a_opcode = op; m1_if.a_size = 3'd2; m1_if.a_source = src;
      m1_if.a_address = addr; m1_if.a_mask = 4'hF; m1_if.a_data = data;
    end
  endtask

  task automatic drop_req(input int m);
    if (m == 0) m0_if.a_valid = 1'b0;
    else        m1_if.a_valid = 1'b0;
  endtask

  task automatic set_d_ready(input int m, input logic v);
    if (m == 0) m0_if.d_ready = v;
    else        m1_if.d_ready = v;
  endtask

  task automatic drive_ram_d(input logic [2:0] op, input logic [31:0] data, input logic [3:0] src);
    ram_if.d_valid = 1'b1; ram_if.d_opcode = op; ram_if.d_size = 3'd2;
    ram_if.d_source = src; ram_if.d_data = data;
  endtask

  function automatic logic a_ready_of(input int m);
    return (m == 0) ? m0_if.a_ready : m1_if.a_ready;
  endfunction

  function automatic logic d_valid_of(input int m);
    return (m == 0) ? m0_if.d_valid : m1_if.d_valid;
  endfunction

  // One lone-master transaction, entered and left in IDLE; stalls on A (ram) and D (master).
  task automatic do_txn(input int m, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] src,
                        input int a_stall, input int d_stall, input logic [31:0] rdata);
    int         acc0;
    logic [2:0] rop;
    rop = (op == TL_GET) ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
    exp_a_q.push_back('{op, addr, data});
    exp_d_q.push_back('{m, rop, rdata, src});
    acc0 = m_acc[m];
    drive_req(m, op, addr, data, src);
    ram_if.a_ready = 1'b0;
    #1;
    tests++;
    if (ram_if.a_valid !== 1'b0 || a_ready_of(m) !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_accept: ram.a_valid=%b a_ready=%b, required 0 0", ram_if.a_valid, a_ready_of(m));
    end
    tick();
    for (int k = 0; k < a_stall; k++) begin
      #1;
      tests++;
      if (ram_if.a_valid !== 1'b1 || ram_if.a_address !== addr || ram_if.a_data !== data ||
          ram_if.a_opcode !== op || a_ready_of(m) !== 1'b0) begin
        fails++;
        $display("FAIL a_stall[%0d]: valid=%b addr=%h data=%h op=%0d a_ready=%b, required 1 %h %h %0d 0",
                 k, ram_if.a_valid, ram_if.a_address, ram_if.a_data, ram_if.a_opcode, a_ready_of(m),
                 addr, data, op);
      end
      tick();
    end
    ram_if.a_ready = 1'b1;
    #1;
    tests++;
    if (ram_if.a_valid !== 1'b1 || grant !== (m == 1) || a_ready_of(m) !== 1'b1) begin
      fails++;
      $display("FAIL a_accept: ram.a_valid=%b grant=%b a_ready=%b, required 1 %0d 1",
               ram_if.a_valid, grant, a_ready_of(m), m);
    end
    tick();
    ram_if.a_ready = 1'b0;
    drop_req(m);
    drive_ram_d(rop, rdata, src);
    for (int k = 0; k < d_stall; k++) begin
      set_d_ready(m, 1'b0);
      #1;
      tests++;
      if (ram_if.d_ready !== 1'b0 || d_valid_of(m) !== 1'b1 || d_valid_of(1 - m) !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL d_stall[%0d]: ram.d_ready=%b d_valid=%b other=%b busy=%b, required 0 1 0 1",
                 k, ram_if.d_ready, d_valid_of(m), d_valid_of(1 - m), busy);
      end
      tick();
    end
    set_d_ready(m, 1'b1);
    #1;
    tests++;
    if (ram_if.d_ready !== 1'b1 || d_valid_of(m) !== 1'b1 || d_valid_of(1 - m) !== 1'b0) begin
      fails++;
      $display("FAIL d_complete: ram.d_ready=%b d_valid=%b other=%b, required 1 1 0",
               ram_if.d_ready, d_valid_of(m), d_valid_of(1 - m));
    end
    tick();
    ram_if.d_valid = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || (m_acc[m] - acc0) != 1) begin
      fails++;
      $display("FAIL txn_end: busy=%b a_accepts=%0d, required 0 1", busy, m_acc[m] - acc0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy, grant, timeout, m0_if.a_ready, m1_if.a_ready, m0_if.d_valid, m1_if.d_valid,
         ram_if.a_valid, ram_if.d_ready} !== 9'b0 || err_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_outputs: busy/grant/timeout/a_rdy0/a_rdy1/d_vld0/d_vld1/ram_av/ram_dr=%b err_count=%0d, required all 0",
               {busy, grant, timeout, m0_if.a_ready, m1_if.a_ready, m0_if.d_valid, m1_if.d_valid,
                ram_if.a_valid, ram_if.d_ready}, err_count);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    tests++;
    if (ram_if.d_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_sink_ready: ram.d_ready=%b busy=%b, required 1 0", ram_if.d_ready, busy);
    end
  endtask

  task automatic test_round_robin();
    drive_req(0, TL_GET, 32'h0000_1000, 32'h0, 4'd1);
    drive_req(1, TL_GET, 32'h0000_2000, 32'h0, 4'd2);
    for (int t = 0; t < 4; t++) begin
      int         em;
      logic [31:0] ea;
      logic [3:0] es;
      em = t % 2;
      ea = (em == 1) ? 32'h0000_2000 : 32'h0000_1000;
      es = (em == 1) ? 4'd2 : 4'd1;
      exp_a_q.push_back('{TL_GET, ea, 32'h0});
      exp_d_q.push_back('{em, TL_ACCESS_ACK_DATA, 32'hB000_0000 + t, es});
      tick();
      ram_if.a_ready = 1'b1;
      #1;
      tests++;
      if (grant !== (em == 1) || ram_if.a_address !== ea) begin
        fails++;
        $display("FAIL rr_grant[%0d]: grant=%b addr=%h, required %0d %h", t, grant, ram_if.a_address, em, ea);
      end
      tick();
      ram_if.a_ready = 1'b0;
      drive_ram_d(TL_ACCESS_ACK_DATA, 32'hB000_0000 + t, es);
      tick();
      ram_if.d_valid = 1'b0;
    end
    drop_req(0);
    drop_req(1);
    #1;
  endtask

  task automatic test_single_get();
    do_txn(0, TL_GET, 32'h8000_0000, 32'h0, 4'd3, 0, 0, 32'h1234_5678);
  endtask

  task automatic test_put_stall();
    do_txn(1, TL_PUT_F, 32'h0000_0100, 32'hDEAD_BEEF, 4'd5, 5, 0, 32'h0);
  endtask

  task automatic test_d_backpressure();
    do_txn(0, TL_GET, 32'h0000_0040, 32'h0, 4'd1, 0, 4, 32'hCAFE_F00D);
  endtask

  task automatic test_back_to_back();
    do_txn(0, TL_GET, 32'h0000_0044, 32'h0, 4'd7, 0, 0, 32'h0BAD_CAFE);
    do_txn(0, TL_PUT_P, 32'h0000_0048, 32'h1111_2222, 4'd8, 0, 0, 32'h0);
  endtask

  task automatic test_timeout();
    exp_d_q.push_back('{0, TL_ACCESS_ACK_DATA, 32'h0, 4'd2});
    drive_req(0, TL_GET, 32'h0000_0200, 32'h0, 4'd2);
    ram_if.a_ready = 1'b0;
    m0_if.d_ready  = 1'b1;
    tick();
    for (int c = 1; c <= 8; c++) begin
      #1;
      tests++;
      if (timeout !== (c == 8)) begin
        fails++;
        $display("FAIL timeout_pulse[cycle %0d]: timeout=%b, required %0d", c, timeout, c == 8);
      end
      tick();
    end
    drop_req(0);
    #1;
    tests++;
    if (err_count !== 16'd1 || timeout !== 1'b0 || ram_if.a_valid !== 1'b0 || m0_if.d_valid !== 1'b1 ||
        m1_if.d_valid !== 1'b0) begin
      fails++;
      $display("FAIL timeout_resp: err_count=%0d timeout=%b ram.a_valid=%b m0.d_valid=%b m1.d_valid=%b, required 1 0 0 1 0",
               err_count, timeout, ram_if.a_valid, m0_if.d_valid, m1_if.d_valid);
    end
    tick();
    drive_ram_d(TL_ACCESS_ACK_DATA, 32'h5555_AAAA, 4'd2);
    #1;
    tests++;
    if (ram_if.d_ready !== 1'b1 || m0_if.d_valid !== 1'b0 || m1_if.d_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL stray_sink: ram.d_ready=%b m0.d_valid=%b m1.d_valid=%b busy=%b, required 1 0 0 0",
               ram_if.d_ready, m0_if.d_valid, m1_if.d_valid, busy);
    end
    tick();
    ram_if.d_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid();
    exp_a_q.push_back('{TL_GET, 32'h0000_0300, 32'h0});
    drive_req(0, TL_GET, 32'h0000_0300, 32'h0, 4'd6);
    ram_if.a_ready = 1'b1;
    tick();
    tick();
    drop_req(0);
    ram_if.a_ready = 1'b0;
    m0_if.d_ready  = 1'b0;
    drive_ram_d(TL_ACCESS_ACK_DATA, 32'h7777_7777, 4'd6);
    #1;
    tests++;
    if (busy !== 1'b1 || m0_if.d_valid !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_wait_d: busy=%b m0.d_valid=%b, required 1 1", busy, m0_if.d_valid);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({busy, grant, timeout, m0_if.a_ready, m1_if.a_ready, m0_if.d_valid, m1_if.d_valid,
         ram_if.a_valid, ram_if.d_ready} !== 9'b0 || err_count !== 16'd0) begin
      fails++;
      $display("FAIL reset_mid_outputs: busy/grant/timeout/a_rdy0/a_rdy1/d_vld0/d_vld1/ram_av/ram_dr=%b err_count=%0d, required all 0",
               {busy, grant, timeout, m0_if.a_ready, m1_if.a_ready, m0_if.d_valid, m1_if.d_valid,
                ram_if.a_valid, ram_if.d_ready}, err_count);
    end
    idle_all();
    @(negedge clk);
    rst = 1'b0;
    tick();
    exp_a_q.push_back('{TL_GET, 32'h0000_0400, 32'h0});
    exp_d_q.push_back('{0, TL_ACCESS_ACK_DATA, 32'h4444_0000, 4'd1});
    drive_req(0, TL_GET, 32'h0000_0400, 32'h0, 4'd1);
    drive_req(1, TL_GET, 32'h0000_0500, 32'h0, 4'd2);
    tick();
    drop_req(1);
    ram_if.a_ready = 1'b1;
    #1;
    tests++;
    if (grant !== 1'b0 || ram_if.a_address !== 32'h0000_0400) begin
      fails++;
      $display("FAIL post_reset_grant: grant=%b addr=%h, required 0 00000400", grant, ram_if.a_address);
    end
    tick();
    drop_req(0);
    ram_if.a_ready = 1'b0;
    drive_ram_d(TL_ACCESS_ACK_DATA, 32'h4444_0000, 4'd1);
    tick();
    ram_if.d_valid = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_time_limit: run did not finish within 100000 time units");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single_get();
    test_put_stall();
    test_d_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    tick();
    tests++;
    if (exp_a_q.size() != 0 || exp_d_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: pending a=%0d d=%0d, required 0 0", exp_a_q.size(), exp_d_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
